md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_md_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: HI/LO multiply-divide unit for a MIPS-style pipeline.
//
// Purpose
//   Runs multiply-class ops for MULT_CYCLES cycles and divide-class ops for
//   DIV_CYCLES cycles, then writes the 64-bit result into the architectural
//   HI/LO pair in a single edge. mthi/mtlo write HI/LO directly with no busy
//   period. HI/LO only ever change on a completed op, a move, or reset.
//
// Parameters
//   MULT_CYCLES  busy duration of mult/multu (and madd/msub family), >= 1
//   DIV_CYCLES   busy duration of div/divu, >= 1
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-low reset
//   start    in   1   one-cycle launch pulse for HILO_Op
//   HILO_Op  in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                     7 madd, 8 maddu, 9 msub, 10 msubu; other codes none
//   A        in  32   rs operand
//   B        in  32   rt operand
//   busy     out  1   high while an op is in flight
//   HI       out 32   architectural HI register
//   LO       out 32   architectural LO register
//
// Configuration
//   MD_UNIT_MACC_EN  when defined, ops 7-10 accumulate into {HI,LO};
//                    otherwise they behave as "none".

module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  HILO_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    // The counter holds N-1 at most; keep it at least 4 bits wide.
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 4) ? 4 : $clog2(MAX_CYC);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_isMul;
    logic        w_isDiv;
    logic [63:0] w_prodS;
    logic [63:0] w_prodU;
    logic        w_signedDiv;
    logic        w_negA;
    logic        w_negB;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_dvsSafe;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_wr;
    logic [63:0] w_res;

    // busy depends only on state, never on start, so the stall path
    // start_E|busy has no combinational loop through this unit.
    assign busy = (r_state != S_IDLE);
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Launch decode; accumulate ops only count as multiply-class when built in.
    always_comb begin
        w_isMul = (HILO_Op == OP_MULT) || (HILO_Op == OP_MULTU);
        w_isDiv = (HILO_Op == OP_DIV)  || (HILO_Op == OP_DIVU);
`ifdef MD_UNIT_MACC_EN
        if ((HILO_Op == OP_MADD) || (HILO_Op == OP_MADDU) ||
            (HILO_Op == OP_MSUB) || (HILO_Op == OP_MSUBU)) begin
            w_isMul = 1'b1;
        end
`endif
    end

    // 64-bit products from the latched operands; the signed one uses explicit
    // sign extension so the low 64 bits are the two's-complement product.
    assign w_prodS = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prodU = {32'd0, r_a} * {32'd0, r_b};

    // Signed division is done on magnitudes and fixed up afterwards. This
    // makes 0x80000000 / -1 come out as 0x80000000 rem 0 without relying on
    // overflow behaviour of a native signed divide.
    assign w_signedDiv = (r_op == OP_DIV);
    assign w_negA      = w_signedDiv && r_a[31];
    assign w_negB      = w_signedDiv && r_b[31];
    assign w_dvd       = w_negA ? (~r_a + 32'd1) : r_a;
    assign w_dvs       = w_negB ? (~r_b + 32'd1) : r_b;
    assign w_dvsSafe   = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
    assign w_q         = w_dvd / w_dvsSafe;
    assign w_r         = w_dvd % w_dvsSafe;
    assign w_quo       = (w_negA ^ w_negB) ? (~w_q + 32'd1) : w_q;
    assign w_rem       = w_negA ? (~w_r + 32'd1) : w_r;

    // Result selection for the final busy cycle. Division by zero
    // suppresses the write but still uses the full busy period.
    always_comb begin
        w_wr  = 1'b0;
        w_res = {r_hi, r_lo};
        case (r_op)
            OP_MULT: begin
                w_wr  = 1'b1;
                w_res = w_prodS;
            end
            OP_MULTU: begin
                w_wr  = 1'b1;
                w_res = w_prodU;
            end
            OP_DIV, OP_DIVU: begin
                w_wr  = (r_b != 32'd0);
                w_res = {w_rem, w_quo};
            end
`ifdef MD_UNIT_MACC_EN
            OP_MADD: begin
                w_wr  = 1'b1;
                w_res = {r_hi, r_lo} + w_prodS;
            end
            OP_MADDU: begin
                w_wr  = 1'b1;
                w_res = {r_hi, r_lo} + w_prodU;
            end
            OP_MSUB: begin
                w_wr  = 1'b1;
                w_res = {r_hi, r_lo} - w_prodS;
            end
            OP_MSUBU: begin
                w_wr  = 1'b1;
                w_res = {r_hi, r_lo} - w_prodU;
            end
`endif
            default: begin
                w_wr  = 1'b0;
                w_res = {r_hi, r_lo};
            end
        endcase
    end

    // Controller: starts are only looked at in IDLE, so a start during busy
    // is dropped. The counter is loaded with N-1 and the write happens on
    // the edge where it reads 0, giving exactly N busy cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_op    <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_isMul) begin
                            r_state <= S_MUL;
                            r_count <= CNT_W'(MULT_CYCLES - 1);
                            r_op    <= HILO_Op;
                            r_a     <= A;
                            r_b     <= B;
                        end else if (w_isDiv) begin
                            r_state <= S_DIV;
                            r_count <= CNT_W'(DIV_CYCLES - 1);
                            r_op    <= HILO_Op;
                            r_a     <= A;
                            r_b     <= B;
                        end else if (HILO_Op == OP_MTHI) begin
                            r_hi <= A;
                        end else if (HILO_Op == OP_MTLO) begin
                            r_lo <= A;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_count == '0) begin
                        r_state <= S_IDLE;
                        if (w_wr) begin
                            r_hi <= w_res[63:32];
                            r_lo <= w_res[31:0];
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed, self-checking bench for md_unit with default
// MULT_CYCLES=5 and DIV_CYCLES=10. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.

module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  HILO_Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int nVectors;
    int nMiscompares;

    md_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .HILO_Op (HILO_Op),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if a loop were ever unbounded.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nMiscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive a one-cycle start pulse; returns at the falling edge of cycle T+1.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        HILO_Op = op;
        A       = a;
        B       = b;
        @(negedge clk);
        start   = 1'b0;
        HILO_Op = 4'd0;
    endtask

    // From cycle T+1: busy must hold for n cycles with HI/LO frozen, then
    // drop with the expected result visible.
    task automatic waitBusy(input string tag, input int n,
                            input logic [31:0] holdHi, input logic [31:0] holdLo,
                            input logic [31:0] expHi, input logic [31:0] expLo);
        for (int k = 1; k <= n; k++) begin
            checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, " HI hold"}, HI, holdHi);
            checkOutput({tag, " LO hold"}, LO, holdLo);
            @(negedge clk);
        end
        checkOutput({tag, " busy done"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, " HI"}, HI, expHi);
        checkOutput({tag, " LO"}, LO, expLo);
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        reset   = 1'b0;
        start   = 1'b0;
        HILO_Op = 4'd0;
        A       = 32'd0;
        B       = 32'd0;

        // Reset values before any clock edge
        #1;
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] mult / multu");
        applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3);
        waitBusy("mult", 5, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        applyStimulus(4'd2, 32'hFFFF_FFFE, 32'd3);
        waitBusy("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);

        $display("[TB] div / divu");
        applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2);
        waitBusy("div", 10, 32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        applyStimulus(4'd4, 32'd7, 32'd2);
        waitBusy("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1, 32'd3);

        $display("[TB] mthi and divide by zero");
        applyStimulus(4'd5, 32'h1234_5678, 32'd0);
        checkOutput("mthi busy", {31'd0, busy}, 32'd0);
        checkOutput("mthi HI", HI, 32'h1234_5678);
        checkOutput("mthi LO", LO, 32'd3);
        applyStimulus(4'd3, 32'd5, 32'd0);
        waitBusy("div0", 10, 32'h1234_5678, 32'd3, 32'h1234_5678, 32'd3);

        $display("[TB] div overflow corner");
        applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        waitBusy("divovf", 10, 32'h1234_5678, 32'd3, 32'd0, 32'h8000_0000);

        $display("[TB] none and undefined op codes");
        applyStimulus(4'd0, 32'hAAAA_AAAA, 32'd1);
        checkOutput("op0 busy", {31'd0, busy}, 32'd0);
        checkOutput("op0 HI", HI, 32'd0);
        checkOutput("op0 LO", LO, 32'h8000_0000);
        applyStimulus(4'd15, 32'hAAAA_AAAA, 32'd1);
        checkOutput("op15 busy", {31'd0, busy}, 32'd0);
        checkOutput("op15 HI", HI, 32'd0);
        checkOutput("op15 LO", LO, 32'h8000_0000);

        $display("[TB] start ignored while busy");
        applyStimulus(4'd1, 32'd7, 32'd6);
        checkOutput("ign busy c1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start   = 1'b1;
        HILO_Op = 4'd6;
        A       = 32'hDEAD_BEEF;
        checkOutput("ign busy c2", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start   = 1'b0;
        HILO_Op = 4'd0;
        waitBusy("ign", 3, 32'd0, 32'h8000_0000, 32'd0, 32'h0000_002A);
        @(negedge clk);
        checkOutput("ign LO later", LO, 32'h0000_002A);

        $display("[TB] reset during divide");
        applyStimulus(4'd5, 32'hA5A5_A5A5, 32'd0);
        checkOutput("pre-reset HI", HI, 32'hA5A5_A5A5);
        applyStimulus(4'd3, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort busy c3", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort HI", HI, 32'd0);
        checkOutput("abort LO", LO, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        start   = 1'b1;
        HILO_Op = 4'd1;
        A       = 32'd3;
        B       = 32'd4;
        @(negedge clk);
        start   = 1'b0;
        HILO_Op = 4'd0;
        waitBusy("postreset", 5, 32'd0, 32'd0, 32'd0, 32'd12);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
        end
        checkOutput("no late HI", HI, 32'd0);
        checkOutput("no late LO", LO, 32'd12);
        checkOutput("no late busy", {31'd0, busy}, 32'd0);

        $display("[TB] madd");
        applyStimulus(4'd5, 32'd0, 32'd0);
        applyStimulus(4'd6, 32'hFFFF_FFFF, 32'd0);
        checkOutput("madd pre LO", LO, 32'hFFFF_FFFF);
        applyStimulus(4'd7, 32'd1, 32'd1);
`ifdef MD_UNIT_MACC_EN
        waitBusy("madd", 5, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
`else
        checkOutput("madd off busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("madd off busy later", {31'd0, busy}, 32'd0);
        checkOutput("madd off HI", HI, 32'd0);
        checkOutput("madd off LO", LO, 32'hFFFF_FFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
